// File: rtl/div_issue_ctrl.sv
// Issue controller between the EX stage and a multi-cycle DIV/REM unit: detects a divide,
// stalls the pipe, hands latched operands to the divider and returns its result to writeback.
module div_issue_ctrl #(
  parameter int unsigned TimeoutCycles = 80
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        ex_valid_i,
  input  logic [9:0]  ex_inst_op_f3_i,
  input  logic        ex_is_muldiv_i,
  input  logic [63:0] ex_rs1_data_i,
  input  logic [63:0] ex_rs2_data_i,
  input  logic [4:0]  ex_rd_addr_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        div_ready_o,
  output logic [63:0] div_dividend_o,
  output logic [63:0] div_diviser_o,
  output logic [9:0]  div_inst_op_f3_o,
  input  logic [63:0] div_rem_data_i,
  input  logic        div_finish_i,
  input  logic        div_busy_i,
  output logic        wb_valid_o,
  output logic [4:0]  wb_rd_addr_o,
  output logic [63:0] wb_data_o,
  output logic        err_timeout_o
);

  localparam int unsigned WdW = $clog2(TimeoutCycles + 1);
  localparam logic [6:0] OpcOp   = 7'b0110011;
  localparam logic [6:0] OpcOp32 = 7'b0111011;

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StDone, StDrain} state_e;

  state_e         state_q, state_d;
  logic [WdW-1:0] wd_q, wd_d;
  logic [63:0]    rs1_q, rs1_d;
  logic [63:0]    rs2_q, rs2_d;
  logic [63:0]    wb_data_q, wb_data_d;
  logic [9:0]     op_q, op_d;
  logic [4:0]     rd_q, rd_d;
  logic           err_q, err_d;
  logic           is_div;
  logic [6:0]     ex_opcode;

  assign ex_opcode = ex_inst_op_f3_i[9:3];
  // funct3 = 1xx selects DIV/DIVU/REM/REMU within the M extension
  assign is_div = ex_valid_i & ex_is_muldiv_i & ex_inst_op_f3_i[2] &
                  ((ex_opcode == OpcOp) | (ex_opcode == OpcOp32));

  always_comb begin
    state_d     = state_q;
    wd_d        = wd_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    op_d        = op_q;
    rd_d        = rd_q;
    wb_data_d   = wb_data_q;
    err_d       = 1'b0;
    stall_o     = 1'b0;
    div_ready_o = 1'b0;
    wb_valid_o  = 1'b0;

    unique case (state_q)
      StIdle: begin
        stall_o = is_div & ~flush_i;
        if (is_div && !flush_i && !div_busy_i) begin
          rs1_d   = ex_rs1_data_i;
          rs2_d   = ex_rs2_data_i;
          op_d    = ex_inst_op_f3_i;
          rd_d    = ex_rd_addr_i;
          state_d = StIssue;
        end
      end
      StIssue: begin
        // The divider cannot abort, so a flush here still issues and then drains.
        stall_o     = 1'b1;
        div_ready_o = 1'b1;
        wd_d        = '0;
        state_d     = flush_i ? StDrain : StWait;
      end
      StWait: begin
        stall_o = 1'b1;
        wd_d    = wd_q + 1'b1;
        if (div_finish_i) begin
          if (flush_i) begin
            state_d = StIdle;
          end else begin
            wb_data_d = div_rem_data_i;
            state_d   = StDone;
          end
        end else if (flush_i) begin
          state_d = StDrain;
        end else if (wd_d == WdW'(TimeoutCycles)) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      StDone: begin
        wb_valid_o = ~flush_i;
        state_d    = StIdle;
      end
      StDrain: begin
        stall_o = is_div;
        if (div_finish_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      wd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      op_q      <= '0;
      rd_q      <= '0;
      wb_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wd_q      <= wd_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      wb_data_q <= wb_data_d;
      err_q     <= err_d;
    end
  end

  assign div_dividend_o   = rs1_q;
  assign div_diviser_o    = rs2_q;
  assign div_inst_op_f3_o = op_q;
  assign wb_rd_addr_o     = rd_q;
  assign wb_data_o        = wb_data_q;
  assign err_timeout_o    = err_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Randomised scoreboard bench for div_issue_ctrl with a behavioural 66-cycle divider model.
module tb_div_issue_ctrl;

  localparam int DivLat = 66;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic [9:0]  ex_inst_op_f3;
  logic        ex_is_muldiv;
  logic [63:0] ex_rs1_data, ex_rs2_data;
  logic [4:0]  ex_rd_addr;
  logic        flush;
  logic        stall_o, div_ready, wb_valid, err_timeout;
  logic [63:0] div_dividend, div_diviser, wb_data;
  logic [9:0]  div_inst_op_f3;
  logic [63:0] div_rem_data;
  logic        div_finish, div_busy;
  logic [4:0]  wb_rd_addr;

  typedef struct {logic [4:0] rd; logic [63:0] data;} wb_t;
  wb_t         sb_q[$];
  int unsigned err_q[$];

  int unsigned cyc = 0;
  int unsigned last_ready = 0, last_finish = 0, last_wb = 0, ready_gap = 0;
  int          n_chk = 0, n_pass = 0;
  bit          div_hang = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  div_issue_ctrl #(.TimeoutCycles(80)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .ex_valid_i       (ex_valid),
    .ex_inst_op_f3_i  (ex_inst_op_f3),
    .ex_is_muldiv_i   (ex_is_muldiv),
    .ex_rs1_data_i    (ex_rs1_data),
    .ex_rs2_data_i    (ex_rs2_data),
    .ex_rd_addr_i     (ex_rd_addr),
    .flush_i          (flush),
    .stall_o          (stall_o),
    .div_ready_o      (div_ready),
    .div_dividend_o   (div_dividend),
    .div_diviser_o    (div_diviser),
    .div_inst_op_f3_o (div_inst_op_f3),
    .div_rem_data_i   (div_rem_data),
    .div_finish_i     (div_finish),
    .div_busy_i       (div_busy),
    .wb_valid_o       (wb_valid),
    .wb_rd_addr_o     (wb_rd_addr),
    .wb_data_o        (wb_data),
    .err_timeout_o    (err_timeout)
  );

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endfunction

  // RISC-V M-extension divide semantics, including divide-by-zero and overflow rules.
  function automatic logic [63:0] ref_div(input logic [2:0] f3, input bit w,
                                          input logic [63:0] a, input logic [63:0] b);
    longint      sa, sb;
    int          sa32, sb32;
    logic [31:0] r32;
    logic [63:0] r;
    r = '0;
    if (!w) begin
      sa = a;
      sb = b;
      case (f3)
        3'b100: if (b == 0) r = '1; else if (a == 64'h8000_0000_0000_0000 && b == '1) r = a;
                else r = sa / sb;
        3'b101: if (b == 0) r = '1; else r = a / b;
        3'b110: if (b == 0) r = a; else if (a == 64'h8000_0000_0000_0000 && b == '1) r = '0;
                else r = sa % sb;
        3'b111: if (b == 0) r = a; else r = a % b;
        default: r = '0;
      endcase
    end else begin
      sa32 = a[31:0];
      sb32 = b[31:0];
      case (f3)
        3'b100: if (b[31:0] == 0) r32 = '1;
                else if (a[31:0] == 32'h8000_0000 && b[31:0] == '1) r32 = a[31:0];
                else r32 = sa32 / sb32;
        3'b101: if (b[31:0] == 0) r32 = '1; else r32 = a[31:0] / b[31:0];
        3'b110: if (b[31:0] == 0) r32 = a[31:0];
                else if (a[31:0] == 32'h8000_0000 && b[31:0] == '1) r32 = '0;
                else r32 = sa32 % sb32;
        3'b111: if (b[31:0] == 0) r32 = a[31:0]; else r32 = a[31:0] % b[31:0];
        default: r32 = '0;
      endcase
      r = {{32{r32[31]}}, r32};
    end
    return r;
  endfunction

  // Divider: result 66 cycles after the start pulse, computed from the latched operands.
  initial begin : divider_model
    int  cnt;
    bit  active;
    cnt = 0;
    active = 1'b0;
    div_finish = 1'b0;
    div_busy = 1'b0;
    div_rem_data = '0;
    forever begin
      @(posedge clk);
      #2;
      if (!rst_n) begin
        active = 1'b0;
        div_finish = 1'b0;
        div_busy = 1'b0;
      end else begin
        div_finish = 1'b0;
        if (active) begin
          cnt--;
          if (cnt == 0) begin
            div_finish = 1'b1;
            div_rem_data = ref_div(div_inst_op_f3[2:0], div_inst_op_f3[9:3] == 7'b0111011,
                                   div_dividend, div_diviser);
            active = 1'b0;
          end
        end
        if (div_ready && !div_hang) begin
          active = 1'b1;
          cnt = DivLat;
        end
        div_busy = active | div_finish;
      end
    end
  end

  initial begin : monitor
    wb_t         e;
    int unsigned ec;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (div_ready) begin
          ready_gap = cyc - last_finish;
          last_ready = cyc;
        end
        if (div_finish) last_finish = cyc;
        if (wb_valid) begin
          last_wb = cyc;
          if (sb_q.size() == 0) begin
            n_chk++;
            $display("FAIL wb_unexpected: got wb_valid rd=%0d data=%0h, required none (cycle %0d)",
                     wb_rd_addr, wb_data, cyc);
          end else begin
            e = sb_q.pop_front();
            chk("wb_rd_addr", wb_rd_addr, e.rd);
            chk("wb_data", wb_data, e.data);
          end
        end
        if (err_timeout) begin
          if (err_q.size() == 0) begin
            n_chk++;
            $display("FAIL err_unexpected: got err_timeout, required none (cycle %0d)", cyc);
          end else begin
            ec = err_q.pop_front();
            chk("err_timeout_cycle", cyc, ec);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    ex_valid = 1'b0;
    ex_is_muldiv = 1'b0;
    ex_inst_op_f3 = '0;
    ex_rs1_data = '0;
    ex_rs2_data = '0;
    ex_rd_addr = '0;
    flush = 1'b0;
  endtask

  task automatic drive_op(input logic [2:0] f3, input bit w, input logic [63:0] a,
                          input logic [63:0] b, input logic [4:0] rd);
    ex_valid = 1'b1;
    ex_is_muldiv = 1'b1;
    ex_inst_op_f3 = {(w ? 7'b0111011 : 7'b0110011), f3};
    ex_rs1_data = a;
    ex_rs2_data = b;
    ex_rd_addr = rd;
  endtask

  // Holds the op in EX until the pipe advances, then returns one cycle later with EX empty.
  task automatic do_div(input logic [2:0] f3, input bit w, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] rd,
                        output int unsigned t_start, output int unsigned t_release);
    bit done;
    done = 1'b0;
    t_start = cyc;
    t_release = 0;
    drive_op(f3, w, a, b, rd);
    sb_q.push_back('{rd: rd, data: ref_div(f3, w, a, b)});
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (!stall_o) begin
        done = 1'b1;
        t_release = cyc;
      end
    end
    if (!done) begin
      n_chk++;
      $display("FAIL do_div_release: got stall held 300 cycles, required release (cycle %0d)", cyc);
    end
    step();
    drive_idle();
  endtask

  task automatic wait_ready(output int unsigned r);
    bit got;
    got = 1'b0;
    r = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (div_ready) begin
        got = 1'b1;
        r = cyc;
      end
    end
    if (!got) begin
      n_chk++;
      $display("FAIL wait_ready: got no div_ready in 20 cycles, required one (cycle %0d)", cyc);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_stall"}, stall_o, 0);
    chk({tag, "_div_ready"}, div_ready, 0);
    chk({tag, "_dividend"}, div_dividend, 0);
    chk({tag, "_diviser"}, div_diviser, 0);
    chk({tag, "_op"}, div_inst_op_f3, 0);
    chk({tag, "_wb_valid"}, wb_valid, 0);
    chk({tag, "_wb_rd"}, wb_rd_addr, 0);
    chk({tag, "_wb_data"}, wb_data, 0);
    chk({tag, "_err"}, err_timeout, 0);
  endtask

  function automatic logic [63:0] rnd_operand();
    case ($urandom_range(5, 0))
      0: return 64'd0;
      1: return 64'h8000_0000_0000_0000;
      2: return '1;
      3: return {32'h0, $urandom};
      4: return {32'hFFFF_FFFF, $urandom};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin : stimulus
    int unsigned t, tr, r, c0;
    bit          got;
    rst_n = 1'b0;
    drive_idle();
    repeat (3) step();
    @(negedge clk);
    check_all_zero("reset");
    step();
    rst_n = 1'b1;
    step();

    // DIVU 100/7: latency and stall profile
    do_div(3'b101, 1'b0, 64'd100, 64'd7, 5'd3, t, tr);
    chk("divu_ready_latency", last_ready, t + 1);
    chk("divu_wb_cycle", last_wb, t + 68);
    chk("divu_stall_low_cycle", tr, t + 68);
    chk("divu_wb_data", wb_data, 64'd14);

    // REM then DIV back-to-back: DONE plus one IDLE detect cycle separate finish and next start
    do_div(3'b110, 1'b0, -64'sd7, 64'd2, 5'd4, t, tr);
    chk("rem_neg_data", wb_data, '1);
    do_div(3'b100, 1'b0, -64'sd7, 64'd2, 5'd5, t, tr);
    chk("div_neg_data", wb_data, -64'sd3);
    chk("b2b_ready_gap", ready_gap, 3);

    // divide by zero
    do_div(3'b100, 1'b0, 64'd5, 64'd0, 5'd6, t, tr);
    chk("div_by_zero", wb_data, 64'hFFFF_FFFF_FFFF_FFFF);
    do_div(3'b111, 1'b0, 64'd5, 64'd0, 5'd7, t, tr);
    chk("remu_by_zero", wb_data, 64'd5);

    // flush 10 cycles into WAIT, then a DIVW that must wait for the drained result
    drive_op(3'b101, 1'b0, 64'd1000, 64'd3, 5'd8);
    wait_ready(r);
    step();
    while (cyc < r + 10) step();
    flush = 1'b1;
    ex_valid = 1'b0;
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_stall_drop", stall_o, 0);
    step();
    do_div(3'b100, 1'b1, -64'sd100, 64'd7, 5'd9, t, tr);
    chk("drain_ready_gap", ready_gap, 2);
    chk("divw_data", wb_data, 64'hFFFF_FFFF_FFFF_FFF2);

    // watchdog: divider never finishes
    div_hang = 1'b1;
    c0 = cyc;
    err_q.push_back(c0 + 82);
    drive_op(3'b101, 1'b0, 64'd9, 64'd3, 5'd10);
    wait_ready(r);
    step();
    drive_idle();
    got = 1'b0;
    for (int i = 0; i < 120 && !got; i++) begin
      @(negedge clk);
      if (err_timeout) begin
        got = 1'b1;
        chk("timeout_stall", stall_o, 0);
        chk("timeout_wb", wb_valid, 0);
      end
    end
    if (!got) begin
      n_chk++;
      $display("FAIL timeout_wait: got no err_timeout in 120 cycles, required one (cycle %0d)", cyc);
    end
    step();
    div_hang = 1'b0;
    step();

    // reset mid-WAIT
    drive_op(3'b101, 1'b0, 64'd77, 64'd7, 5'd11);
    wait_ready(r);
    step();
    while (cyc < r + 5) step();
    rst_n = 1'b0;
    drive_idle();
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("midreset");
    step();
    do_div(3'b111, 1'b0, 64'd77, 64'd5, 5'd12, t, tr);
    chk("post_reset_latency", last_wb, t + 68);
    chk("post_reset_data", wb_data, 64'd2);

    // randomised mix of divides and non-divide instructions
    for (int k = 0; k < 12; k++) begin
      if ($urandom_range(3, 0) == 0) begin
        ex_valid = 1'b1;
        ex_rd_addr = 5'($urandom);
        case ($urandom_range(2, 0))
          0: begin ex_is_muldiv = 1'b1; ex_inst_op_f3 = {7'b0110011, 3'($urandom_range(3, 0))}; end
          1: begin ex_is_muldiv = 1'b0; ex_inst_op_f3 = {7'b0110011, 3'($urandom_range(7, 4))}; end
          default: begin ex_is_muldiv = 1'b1; ex_inst_op_f3 = {7'b0010011, 3'($urandom_range(7, 4))}; end
        endcase
        @(negedge clk);
        chk("nondiv_no_stall", stall_o, 0);
        step();
        drive_idle();
      end else begin
        do_div(3'($urandom_range(7, 4)), 1'($urandom_range(1, 0)), rnd_operand(), rnd_operand(),
               5'($urandom), t, tr);
      end
      repeat ($urandom_range(2, 0)) step();
    end

    repeat (5) step();
    chk("sb_drained", sb_q.size(), 0);
    chk("err_drained", err_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin : global_bound
    #2_000_000;
    $display("FAIL global_timeout: got simulation still running, required finish (cycle %0d)", cyc);
    $fatal(1, "bench time limit");
  end

endmodule
